// File: rtl/id_token_logger_if.sv
// Purpose: bundles the match input and the record-FIFO read side of id_token_logger.
// Latency: none, wires only.
// Backpressure: valid/ready on the read side; the match stream cannot be stalled.
`timescale 1ns/1ps
interface id_token_logger_if #(
    parameter int DEPTH = 8,
    parameter int POS_W = 16,
    parameter int LEN_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             match;
    logic             rd_ready;
    logic             rd_valid;
    logic [POS_W-1:0] rd_pos;
    logic [LEN_W-1:0] rd_len;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic [15:0]      total;

    // Source/consumer side: drives the match stream and the read acceptance.
    modport master (
        output match, rd_ready,
        input  rd_valid, rd_pos, rd_len, level, overflow, total
    );

    // Logger side.
    modport slave (
        input  match, rd_ready,
        output rd_valid, rd_pos, rd_len, level, overflow, total
    );
endinterface

// File: rtl/id_token_logger.sv
// Purpose: turns contiguous high runs of the recognizer match flag into {end pos, run length} records held in a FIFO.
// Latency: a record is readable the cycle after its run-end edge; no same-cycle bypass.
// Backpressure: drained via valid/ready; when full, a new record is dropped (or, with TOKEN_LOG_OVERWRITE_EN, replaces the oldest) and overflow sticks.
`timescale 1ns/1ps
module id_token_logger #(
    parameter int DEPTH = 8,
    parameter int POS_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    id_token_logger_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX   = '1;
    localparam logic [15:0]      TOTAL_MAX = 16'hFFFF;
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    // Run tracking state
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_last_pos;
    logic [LEN_W-1:0] r_run_len;
    logic             r_prev_match;

    // FIFO state
    logic [POS_W-1:0] r_mem_pos [DEPTH];
    logic [LEN_W-1:0] r_mem_len [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;
    logic [15:0]      r_total;

    logic w_run_end;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_write;
    logic w_adv_rd;
    logic w_ovf_set;

    assign w_run_end = r_prev_match & ~bus.match;
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LVL_FULL);
    assign w_pop     = ~w_empty & bus.rd_ready;

    // Decide what the FIFO does this edge: normal push/pop, or the full-without-pop case.
    always_comb begin
        w_write   = w_run_end;
        w_adv_rd  = w_pop;
        w_ovf_set = 1'b0;
        if (w_run_end && w_full && !w_pop) begin
            w_ovf_set = 1'b1;
`ifdef TOKEN_LOG_OVERWRITE_EN
            // Evict the oldest entry so the newest record always survives.
            w_write  = 1'b1;
            w_adv_rd = 1'b1;
`else
            // Keep the oldest entries; the newest record is lost.
            w_write  = 1'b0;
`endif
        end
    end

    // Slot counter and per-run tracking of length and last high position.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos        <= '0;
            r_last_pos   <= '0;
            r_run_len    <= '0;
            r_prev_match <= 1'b0;
        end else begin
            r_pos        <= r_pos + POS_W'(1);
            r_prev_match <= bus.match;
            if (bus.match) begin
                r_last_pos <= r_pos;
                r_run_len  <= (r_run_len == LEN_MAX) ? LEN_MAX : r_run_len + LEN_W'(1);
            end else begin
                r_run_len  <= '0;
            end
        end
    end

    // Record storage; contents need no reset because reads are gated by level.
    always_ff @(posedge clk) begin
        if (!reset && w_write) begin
            r_mem_pos[r_wr_ptr] <= r_last_pos;
            r_mem_len[r_wr_ptr] <= r_run_len;
        end
    end

    // Pointers, occupancy, sticky overflow and the saturating run counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_total    <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_adv_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_write && !w_adv_rd) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_adv_rd && !w_write) begin
                r_level <= r_level - LVL_W'(1);
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_run_end && (r_total != TOTAL_MAX)) begin
                r_total <= r_total + 16'd1;
            end
        end
    end

    assign bus.rd_valid = ~w_empty;
    assign bus.rd_pos   = w_empty ? '0 : r_mem_pos[r_rd_ptr];
    assign bus.rd_len   = w_empty ? '0 : r_mem_len[r_rd_ptr];
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
    assign bus.total    = r_total;
endmodule

// File: tb/tb_id_token_logger.sv
// Purpose: directed stimulus for id_token_logger with a queue scoreboard checked by a separate monitor.
// Latency: expected records are queued as run-end edges are issued and compared when the DUT hands them out.
// Backpressure: rd_ready is driven per directed phase; the monitor compares on every valid&&ready cycle.
`timescale 1ns/1ps
module tb_id_token_logger;
    typedef struct packed {
        logic [15:0] pos;
        logic [7:0]  len;
    } rec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    rec_t exp_q[$];

    id_token_logger_if #(.DEPTH(8), .POS_W(16), .LEN_W(8)) bus ();
    id_token_logger_if #(.DEPTH(4), .POS_W(4),  .LEN_W(8)) sbus ();

    id_token_logger #(.DEPTH(8), .POS_W(16), .LEN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    id_token_logger #(.DEPTH(4), .POS_W(4), .LEN_W(8)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every record the consumer accepts must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got pos %0d len %0d with nothing expected",
                         bus.rd_pos, bus.rd_len);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                chk("rec_pos", 32'(bus.rd_pos), 32'(e.pos));
                chk("rec_len", 32'(bus.rd_len), 32'(e.len));
            end
        end
    end

    task automatic cyc(input logic m, input logic r);
        bus.match    = m;
        bus.rd_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.match     = 1'b0;
        bus.rd_ready  = 1'b0;
        sbus.match    = 1'b0;
        sbus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic expect_rec(input int p, input int l);
        rec_t e;
        e.pos = 16'(p);
        e.len = 8'(l);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (bus.level != 0 && budget < 20) begin
            cyc(1'b0, 1'b1);
            budget++;
        end
        bus.rd_ready = 1'b0;
        chk("drain_level", 32'(bus.level), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;

        // Reset state
        do_reset();
        chk("rst_valid",    32'(bus.rd_valid), 32'd0);
        chk("rst_pos",      32'(bus.rd_pos),   32'd0);
        chk("rst_len",      32'(bus.rd_len),   32'd0);
        chk("rst_level",    32'(bus.level),    32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_total",    32'(bus.total),    32'd0);

        // 1: match 0,1,1,1,0 at pos 0..4 -> {3,3}, visible only after the pos-4 edge
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("t1_not_early", 32'(bus.rd_valid), 32'd0);
        expect_rec(3, 3);
        cyc(1'b0, 1'b1);
        chk("t1_valid", 32'(bus.rd_valid), 32'd1);
        chk("t1_total", 32'(bus.total),    32'd1);
        chk("t1_level", 32'(bus.level),    32'd1);
        drain();

        // 2: nine 1-cycle runs at pos 1,3,..,17 with no reads
        do_reset();
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0);
            if (i < 8) begin
                expect_rec(2 * i + 1, 1);
            end else begin
`ifdef TOKEN_LOG_OVERWRITE_EN
                void'(exp_q.pop_front());
                expect_rec(17, 1);
`endif
            end
            cyc(1'b0, 1'b0);
            if (i == 7) begin
                chk("t2_full_level", 32'(bus.level),    32'd8);
                chk("t2_full_noovf", 32'(bus.overflow), 32'd0);
            end
        end
        chk("t2_level",    32'(bus.level),    32'd8);
        chk("t2_overflow", 32'(bus.overflow), 32'd1);
        chk("t2_total",    32'(bus.total),    32'd9);
`ifdef TOKEN_LOG_OVERWRITE_EN
        chk("t2_head_pos", 32'(bus.rd_pos), 32'd3);
`else
        chk("t2_head_pos", 32'(bus.rd_pos), 32'd1);
`endif
        chk("t2_head_len", 32'(bus.rd_len), 32'd1);
        drain();
        chk("t2_ovf_sticky", 32'(bus.overflow), 32'd1);

        // 3: full FIFO, run ends while the head is popped on the same edge
        do_reset();
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0);
            expect_rec(2 * i + 1, 1);
            cyc(1'b0, 1'b0);
        end
        chk("t3_pre_level", 32'(bus.level), 32'd8);
        cyc(1'b1, 1'b0);
        expect_rec(17, 1);
        cyc(1'b0, 1'b1);
        chk("t3_level",    32'(bus.level),    32'd8);
        chk("t3_overflow", 32'(bus.overflow), 32'd0);
        chk("t3_total",    32'(bus.total),    32'd9);
        drain();

        // 4: 300-cycle run saturates the length field
        do_reset();
        repeat (300) cyc(1'b1, 1'b0);
        expect_rec(299, 255);
        cyc(1'b0, 1'b0);
        chk("t4_pos", 32'(bus.rd_pos), 32'd299);
        chk("t4_len", 32'(bus.rd_len), 32'd255);
        drain();

        // 5: reset lands mid-run; stored record and in-progress run both vanish
        do_reset();
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t5_pre_level", 32'(bus.level), 32'd1);
        repeat (4) cyc(1'b1, 1'b0);
        reset     = 1'b1;
        bus.match = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_valid",    32'(bus.rd_valid), 32'd0);
        chk("t5_rst_pos",      32'(bus.rd_pos),   32'd0);
        chk("t5_rst_len",      32'(bus.rd_len),   32'd0);
        chk("t5_rst_level",    32'(bus.level),    32'd0);
        chk("t5_rst_overflow", 32'(bus.overflow), 32'd0);
        chk("t5_rst_total",    32'(bus.total),    32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b0);
        chk("t5_level", 32'(bus.level),    32'd0);
        chk("t5_valid", 32'(bus.rd_valid), 32'd0);
        chk("t5_total", 32'(bus.total),    32'd0);

        // 6: 4-bit position wraps: run over pos 14..17 ends at slot 1
        do_reset();
        for (int p = 0; p <= 18; p++) begin
            sbus.match = (p >= 14 && p <= 17);
            @(posedge clk);
            #1;
        end
        chk("t6_valid", 32'(sbus.rd_valid), 32'd1);
        chk("t6_pos",   32'(sbus.rd_pos),   32'd1);
        chk("t6_len",   32'(sbus.rd_len),   32'd4);
        chk("t6_total", 32'(sbus.total),    32'd1);
        chk("t6_level", 32'(sbus.level),    32'd1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
